// File: rtl/sample_in_fifo_pkg.sv
// Shared defaults for the upsampler input sample buffer: widths, depth
// derivation and error_code bit positions used by the top-level aggregator.
package sample_in_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 4;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  localparam int DEPTH_DEF = depth_of(ADDR_WIDTH_DEF);

  // Bit positions of the sticky flags inside the top-level error_code word.
  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_UDF_BIT = 1;

endpackage

// File: rtl/sample_in_fifo_mem.sv
// Simple dual-port sample storage. SAMPLE_IN_FIFO_FWFT_EN selects an
// asynchronous read port; otherwise the read data is registered on re.
module sample_in_fifo_mem
  import sample_in_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  // Storage is deliberately unreset; stale contents are never presented.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef SAMPLE_IN_FIFO_FWFT_EN
  assign rdata = mem[raddr];

  logic unused_rd_ctrl;
  assign unused_rd_ctrl = rst | re;
`else
  // The read register doubles as the delivered-sample holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/sample_in_fifo.sv
// Circular input sample buffer feeding the upsampler core, with sticky
// overflow/underflow flags. Define SAMPLE_IN_FIFO_FWFT_EN for fall-through reads.
module sample_in_fifo
  import sample_in_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_sample,
  input  logic                  rinc,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] new_sample,
  output logic                  new_sample_valid,
  output logic                  rempty,
  output logic                  full,
  output logic                  afull,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  ovf_err,
  output logic                  udf_err
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = LW'(depth_of(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0]   AFULL_L = LW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE = LW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   level_nxt;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  push, pop, ovf_event, udf_event;

  // A pop frees the head slot in the same cycle, so a full buffer can still accept.
  assign pop       = rinc && !rempty;
  assign push      = in_valid && (!full || pop);
  assign ovf_event = in_valid && !push;
  assign udf_event = rinc && rempty;

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + LVL_ONE;
    else if (pop && !push) level_nxt = level - LVL_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      rempty <= 1'b1;
      full   <= 1'b0;
      afull  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      level  <= level_nxt;
      rempty <= (level_nxt == '0);
      full   <= (level_nxt == DEPTH_L);
      afull  <= (level_nxt >= AFULL_L);
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (ovf_event)    ovf_err <= 1'b1;
      else if (clr_err) ovf_err <= 1'b0;
      if (udf_event)    udf_err <= 1'b1;
      else if (clr_err) udf_err <= 1'b0;
    end
  end

  sample_in_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wptr),
    .wdata (in_sample),
    .re    (pop),
    .raddr (rptr),
    .rdata (rdata)
  );

`ifdef SAMPLE_IN_FIFO_FWFT_EN
  // Mask the unreset storage while nothing is held.
  assign new_sample       = rempty ? '0 : rdata;
  assign new_sample_valid = !rempty;
`else
  assign new_sample = rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) new_sample_valid <= 1'b0;
    else     new_sample_valid <= pop;
  end
`endif

endmodule
